// File: rtl/boa_extmem_sram_mw.sv
// ---------------------------------------------------------------------------
// boa_extmem_sram_mw
// Bridges a 32-bit word bus onto a narrower (8/16/32-bit) external SRAM.
// Each bus word is split into 32/dwidth beats. Each beat is held for
// 1+wait_states cycles. Write beats whose byte enables are all zero are
// skipped. Read lanes are gathered in a staging buffer and published on
// bus_rdata only when the transaction completes, so bus_rdata stays stable
// outside the DONE cycle.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   bus_re, bus_we    : read request / write byte enables (write wins)
//   bus_addr          : byte address, bits [1:0] ignored
//   bus_wdata         : 32-bit write data, little-endian lanes
//   bus_rdata         : 32-bit read data, valid in DONE, held otherwise
//   bus_ready         : idle-and-free or transaction complete
//   sram_re, sram_we  : external read / write strobes
//   sram_be           : external byte-lane enables
//   sram_addr         : external word address
//   sram_wdata        : external write data
//   sram_rdata        : external read data, sampled at the end of each beat
// ---------------------------------------------------------------------------
module boa_extmem_sram_mw #(
    parameter int alen        = 19,
    parameter int dwidth      = 8,
    parameter int wait_states = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  bus_re,
    input  logic [3:0]                            bus_we,
    input  logic [alen-1:0]                       bus_addr,
    input  logic [31:0]                           bus_wdata,
    output logic [31:0]                           bus_rdata,
    output logic                                  bus_ready,
    output logic                                  sram_re,
    output logic                                  sram_we,
    output logic [dwidth/8-1:0]                   sram_be,
    output logic [alen-$clog2(dwidth/8)-1:0]      sram_addr,
    output logic [dwidth-1:0]                     sram_wdata,
    input  logic [dwidth-1:0]                     sram_rdata
);

    localparam int BPB      = dwidth / 8;
    localparam int LBPB     = $clog2(BPB);
    localparam int BEATS    = 32 / dwidth;
    localparam int BEATBITS = 2 - LBPB;
    localparam int AW       = alen - LBPB;

    typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [BEATS-1:0] mask_q, mask_d;
    logic [3:0]       we_q, we_d;
    logic [alen-3:0]  addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rbuf_q, rbuf_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             req;
    logic             inBeat;
    logic             lastCycle;
    logic             nextFound;
    logic [1:0]       nextBeat;
    logic [1:0]       firstBeat;
    logic [BEATS-1:0] reqMask;
    logic [31:0]      rbufMerged;
    logic [AW-1:0]    wordBase;
    logic             unusedAddrBits;

    // The two low address bits only select a byte inside the word, which the
    // byte enables already express.
    assign unusedAddrBits = ^bus_addr[1:0];

    assign req       = bus_re | (|bus_we);
    assign inBeat    = (state_q == BEAT);
    assign lastCycle = (cnt_q == 4'(wait_states));

    // Base external word address of the latched bus word; low beat-index
    // bits are zero so adding the beat index never carries out of the word.
    assign wordBase = AW'(addr_q) << BEATBITS;

    // Which beats carry work: all of them for a read, only those with a
    // nonzero byte-enable slice for a write. The lowest active beat starts.
    always_comb begin
        reqMask   = '0;
        firstBeat = '0;
        for (int k = 0; k < BEATS; k++) begin
            reqMask[k] = (|bus_we) ? (|bus_we[k*BPB +: BPB]) : 1'b1;
        end
        for (int k = BEATS - 1; k >= 0; k--) begin
            if (reqMask[k]) begin
                firstBeat = 2'(k);
            end
        end
    end

    // Next active beat above the current one, so skipped beats cost nothing.
    always_comb begin
        nextFound = 1'b0;
        nextBeat  = beat_q;
        for (int k = BEATS - 1; k >= 0; k--) begin
            if ((k > int'(beat_q)) && mask_q[k]) begin
                nextFound = 1'b1;
                nextBeat  = 2'(k);
            end
        end
    end

    // Staging buffer with the current beat's lane replaced by the SRAM data.
    always_comb begin
        rbufMerged = rbuf_q;
        rbufMerged[beat_q*dwidth +: dwidth] = sram_rdata;
    end

    // External strobes are decoded from the registered state so they drop
    // the moment reset forces the FSM back to IDLE.
    assign sram_re    = inBeat & ~write_q;
    assign sram_we    = inBeat & write_q;
    assign sram_be    = inBeat ? (write_q ? we_q[beat_q*BPB +: BPB] : '1) : '0;
    assign sram_addr  = inBeat ? (wordBase + AW'(beat_q)) : '0;
    assign sram_wdata = inBeat ? wdata_q[beat_q*dwidth +: dwidth] : '0;
    assign bus_rdata  = rdata_q;
    assign bus_ready  = ~rst & (((state_q == IDLE) & ~req) | (state_q == DONE));

    // Next-state logic: accept in IDLE, step through active beats, then a
    // single DONE cycle which also publishes the gathered read word.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        mask_d  = mask_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BEAT;
                    write_d = |bus_we;
                    we_d    = bus_we;
                    addr_d  = bus_addr[alen-1:2];
                    wdata_d = bus_wdata;
                    mask_d  = reqMask;
                    beat_d  = firstBeat;
                    cnt_d   = '0;
                end
            end
            BEAT: begin
                if (lastCycle) begin
                    if (!write_q) begin
                        rbuf_d = rbufMerged;
                    end
                    if (nextFound) begin
                        beat_d = nextBeat;
                        cnt_d  = '0;
                    end else begin
                        state_d = DONE;
                        if (!write_q) begin
                            rdata_d = rbufMerged;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction without a completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            cnt_q   <= '0;
            write_q <= 1'b0;
            mask_q  <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rbuf_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            mask_q  <= mask_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_boa_extmem_sram_mw.sv
// Testbench for boa_extmem_sram_mw. Four instances cover the byte, byte with
// wait states, halfword and full-word configurations. They share one byte
// memory model and one request driver; only the selected instance sees a
// request.
module tb_boa_extmem_sram_mw;

    logic        clk;
    logic        rst;
    logic        re;
    logic [3:0]  we;
    logic [18:0] addr;
    logic [31:0] wdata;
    int          sel;

    logic [7:0]  mem [256];

    logic        readyV [4];
    logic        reV    [4];
    logic        weV    [4];
    logic [31:0] rdataV [4];
    logic [18:0] saddrV [4];
    logic [3:0]  beV    [4];
    logic [31:0] swdV   [4];

    logic [18:0] sa0, sa1;
    logic [17:0] sa2;
    logic [16:0] sa3;
    logic [0:0]  be0, be1;
    logic [1:0]  be2;
    logic [3:0]  be3;
    logic [7:0]  swd0, swd1, srd0, srd1;
    logic [15:0] swd2, srd2;
    logic [31:0] swd3, srd3;

    int          checks;
    int          errors;
    logic        reqReady;
    logic        bothSeen;
    logic [18:0] logAddr [$];
    logic [3:0]  logBe   [$];
    logic [31:0] logWd   [$];
    logic        logRe   [$];

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous memory model
    assign srd0 = mem[sa0[7:0]];
    assign srd1 = mem[sa1[7:0]];
    assign srd2 = {mem[{sa2[6:0], 1'b1}], mem[{sa2[6:0], 1'b0}]};
    assign srd3 = {mem[{sa3[5:0], 2'd3}], mem[{sa3[5:0], 2'd2}],
                   mem[{sa3[5:0], 2'd1}], mem[{sa3[5:0], 2'd0}]};

    assign saddrV[0] = sa0;
    assign saddrV[1] = sa1;
    assign saddrV[2] = 19'(sa2);
    assign saddrV[3] = 19'(sa3);
    assign beV[0]    = 4'(be0);
    assign beV[1]    = 4'(be1);
    assign beV[2]    = 4'(be2);
    assign beV[3]    = be3;
    assign swdV[0]   = 32'(swd0);
    assign swdV[1]   = 32'(swd1);
    assign swdV[2]   = 32'(swd2);
    assign swdV[3]   = swd3;

    boa_extmem_sram_mw #(.alen(19), .dwidth(8), .wait_states(0)) u0 (
        .clk(clk), .rst(rst),
        .bus_re(re && (sel == 0)), .bus_we((sel == 0) ? we : 4'b0000),
        .bus_addr(addr), .bus_wdata(wdata),
        .bus_rdata(rdataV[0]), .bus_ready(readyV[0]),
        .sram_re(reV[0]), .sram_we(weV[0]), .sram_be(be0),
        .sram_addr(sa0), .sram_wdata(swd0), .sram_rdata(srd0)
    );

    boa_extmem_sram_mw #(.alen(19), .dwidth(8), .wait_states(2)) u1 (
        .clk(clk), .rst(rst),
        .bus_re(re && (sel == 1)), .bus_we((sel == 1) ? we : 4'b0000),
        .bus_addr(addr), .bus_wdata(wdata),
        .bus_rdata(rdataV[1]), .bus_ready(readyV[1]),
        .sram_re(reV[1]), .sram_we(weV[1]), .sram_be(be1),
        .sram_addr(sa1), .sram_wdata(swd1), .sram_rdata(srd1)
    );

    boa_extmem_sram_mw #(.alen(19), .dwidth(16), .wait_states(1)) u2 (
        .clk(clk), .rst(rst),
        .bus_re(re && (sel == 2)), .bus_we((sel == 2) ? we : 4'b0000),
        .bus_addr(addr), .bus_wdata(wdata),
        .bus_rdata(rdataV[2]), .bus_ready(readyV[2]),
        .sram_re(reV[2]), .sram_we(weV[2]), .sram_be(be2),
        .sram_addr(sa2), .sram_wdata(swd2), .sram_rdata(srd2)
    );

    boa_extmem_sram_mw #(.alen(19), .dwidth(32), .wait_states(0)) u3 (
        .clk(clk), .rst(rst),
        .bus_re(re && (sel == 3)), .bus_we((sel == 3) ? we : 4'b0000),
        .bus_addr(addr), .bus_wdata(wdata),
        .bus_rdata(rdataV[3]), .bus_ready(readyV[3]),
        .sram_re(reV[3]), .sram_we(weV[3]), .sram_be(be3),
        .sram_addr(sa3), .sram_wdata(swd3), .sram_rdata(srd3)
    );

    // Issue one request to instance d, log every strobed cycle, and return
    // the cycle offset (from the sampling cycle) at which bus_ready rose.
    task automatic applyStimulus(input int d, input logic r, input logic [3:0] w,
                                 input logic [18:0] a, input logic [31:0] wd,
                                 output int readyAt);
        @(negedge clk);
        sel = d; re = r; we = w; addr = a; wdata = wd;
        logAddr.delete(); logBe.delete(); logWd.delete(); logRe.delete();
        readyAt = -1;
        #1;
        reqReady = readyV[d];
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (reV[d] || weV[d]) begin
                logAddr.push_back(saddrV[d]);
                logBe.push_back(beV[d]);
                logWd.push_back(swdV[d]);
                logRe.push_back(reV[d]);
            end
            if (reV[d] && weV[d]) bothSeen = 1'b1;
            if (readyV[d]) begin
                readyAt = i;
                break;
            end
        end
        re = 1'b0;
        we = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; re = 1'b0; we = 4'b0000; addr = '0; wdata = '0; sel = 0;
        #1 rst = 1'b1;
        #2;
        checks++; if (readyV[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", readyV[0]); end
        checks++; if (reV[0] !== 1'b0 || weV[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes: got re=%b we=%b expected 0 0", reV[0], weV[0]); end
        checks++; if (saddrV[0] !== 19'h0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", saddrV[0]); end
        checks++; if (beV[0] !== 4'h0) begin errors++; $display("[TB] FAIL reset_be: got %h expected 0", beV[0]); end
        checks++; if (swdV[0] !== 32'h0) begin errors++; $display("[TB] FAIL reset_wdata: got %h expected 0", swdV[0]); end
        checks++; if (rdataV[0] !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdataV[0]); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (readyV[0] !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready: got %b expected 1", readyV[0]); end
    endtask

    task automatic test_read_byte;
        int readyAt;
        applyStimulus(0, 1'b1, 4'b0000, 19'h100, 32'h0, readyAt);
        checks++; if (reqReady !== 1'b0) begin errors++; $display("[TB] FAIL read8_req_ready: got %b expected 0", reqReady); end
        checks++; if (readyAt != 5) begin errors++; $display("[TB] FAIL read8_latency: got %0d expected 5", readyAt); end
        checks++; if (logAddr.size() != 4) begin errors++; $display("[TB] FAIL read8_beats: got %0d expected 4", logAddr.size()); end
        for (int k = 0; k < 4 && k < logAddr.size(); k++) begin
            checks++;
            if (logAddr[k] !== 19'(32'h100 + k) || logRe[k] !== 1'b1) begin
                errors++; $display("[TB] FAIL read8_beat%0d: got addr=%h re=%b expected addr=%h re=1", k, logAddr[k], logRe[k], 32'h100 + k);
            end
        end
        checks++; if (rdataV[0] !== 32'h44332211) begin errors++; $display("[TB] FAIL read8_data: got %h expected 44332211", rdataV[0]); end
    endtask

    task automatic test_write_priority;
        int readyAt;
        applyStimulus(0, 1'b1, 4'b1000, 19'h104, 32'h55667788, readyAt);
        checks++; if (readyAt != 2) begin errors++; $display("[TB] FAIL prio_latency: got %0d expected 2", readyAt); end
        checks++; if (logAddr.size() != 1) begin errors++; $display("[TB] FAIL prio_beats: got %0d expected 1", logAddr.size()); end
        if (logAddr.size() > 0) begin
            checks++;
            if (logAddr[0] !== 19'h107 || logWd[0] !== 32'h55 || logBe[0] !== 4'h1 || logRe[0] !== 1'b0) begin
                errors++; $display("[TB] FAIL prio_beat: got addr=%h wd=%h be=%h re=%b expected 107 55 1 0", logAddr[0], logWd[0], logBe[0], logRe[0]);
            end
        end
        checks++; if (rdataV[0] !== 32'h44332211) begin errors++; $display("[TB] FAIL prio_rdata_kept: got %h expected 44332211", rdataV[0]); end
    endtask

    task automatic test_write_sparse;
        int readyAt;
        logic [18:0] expA;
        logic [31:0] expD;
        applyStimulus(1, 1'b0, 4'b0101, 19'h20, 32'hAABBCCDD, readyAt);
        checks++; if (readyAt != 7) begin errors++; $display("[TB] FAIL sparse_latency: got %0d expected 7", readyAt); end
        checks++; if (logAddr.size() != 6) begin errors++; $display("[TB] FAIL sparse_cycles: got %0d expected 6", logAddr.size()); end
        for (int k = 0; k < 6 && k < logAddr.size(); k++) begin
            expA = (k < 3) ? 19'h20 : 19'h22;
            expD = (k < 3) ? 32'hDD : 32'hBB;
            checks++;
            if (logAddr[k] !== expA || logWd[k] !== expD || logBe[k] !== 4'h1 || logRe[k] !== 1'b0) begin
                errors++; $display("[TB] FAIL sparse_cycle%0d: got addr=%h wd=%h be=%h expected addr=%h wd=%h be=1", k, logAddr[k], logWd[k], logBe[k], expA, expD);
            end
        end
        checks++; if (rdataV[1] !== 32'h0) begin errors++; $display("[TB] FAIL sparse_rdata_kept: got %h expected 0", rdataV[1]); end
    endtask

    task automatic test_read_half;
        int readyAt;
        logic [18:0] expA;
        applyStimulus(2, 1'b1, 4'b0000, 19'h8, 32'h0, readyAt);
        checks++; if (readyAt != 5) begin errors++; $display("[TB] FAIL read16_latency: got %0d expected 5", readyAt); end
        checks++; if (logAddr.size() != 4) begin errors++; $display("[TB] FAIL read16_cycles: got %0d expected 4", logAddr.size()); end
        for (int k = 0; k < 4 && k < logAddr.size(); k++) begin
            expA = (k < 2) ? 19'h4 : 19'h5;
            checks++;
            if (logAddr[k] !== expA || logBe[k] !== 4'h3 || logRe[k] !== 1'b1) begin
                errors++; $display("[TB] FAIL read16_cycle%0d: got addr=%h be=%h expected addr=%h be=3", k, logAddr[k], logBe[k], expA);
            end
        end
        checks++; if (rdataV[2] !== 32'h9C77522D) begin errors++; $display("[TB] FAIL read16_data: got %h expected 9c77522d", rdataV[2]); end
    endtask

    task automatic test_write_skip_first;
        int readyAt;
        applyStimulus(2, 1'b0, 4'b1100, 19'h10, 32'hCAFE1234, readyAt);
        checks++; if (readyAt != 3) begin errors++; $display("[TB] FAIL skip16_latency: got %0d expected 3", readyAt); end
        checks++; if (logAddr.size() != 2) begin errors++; $display("[TB] FAIL skip16_cycles: got %0d expected 2", logAddr.size()); end
        if (logAddr.size() > 0) begin
            checks++;
            if (logAddr[0] !== 19'h9 || logWd[0] !== 32'hCAFE || logBe[0] !== 4'h3) begin
                errors++; $display("[TB] FAIL skip16_beat: got addr=%h wd=%h be=%h expected 9 cafe 3", logAddr[0], logWd[0], logBe[0]);
            end
        end
    endtask

    task automatic test_word_wrap;
        int readyAt;
        applyStimulus(3, 1'b1, 4'b0000, 19'h7FFFC, 32'h0, readyAt);
        checks++; if (readyAt != 2) begin errors++; $display("[TB] FAIL read32_latency: got %0d expected 2", readyAt); end
        checks++; if (logAddr.size() != 1) begin errors++; $display("[TB] FAIL read32_beats: got %0d expected 1", logAddr.size()); end
        if (logAddr.size() > 0) begin
            checks++;
            if (logAddr[0] !== 19'h1FFFF || logBe[0] !== 4'hF) begin
                errors++; $display("[TB] FAIL read32_beat: got addr=%h be=%h expected 1ffff f", logAddr[0], logBe[0]);
            end
        end
        checks++; if (rdataV[3] !== 32'hE0BB9671) begin errors++; $display("[TB] FAIL read32_data: got %h expected e0bb9671", rdataV[3]); end
    endtask

    task automatic test_reset_midbeat;
        int readyAt;
        @(negedge clk);
        sel = 0; re = 1'b1; we = 4'b0000; addr = 19'h100;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++; if (reV[0] !== 1'b1) begin errors++; $display("[TB] FAIL midbeat_active: got %b expected 1", reV[0]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (reV[0] !== 1'b0 || weV[0] !== 1'b0) begin errors++; $display("[TB] FAIL midbeat_strobes: got re=%b we=%b expected 0 0", reV[0], weV[0]); end
        checks++; if (readyV[0] !== 1'b0) begin errors++; $display("[TB] FAIL midbeat_ready: got %b expected 0", readyV[0]); end
        checks++; if (rdataV[0] !== 32'h0) begin errors++; $display("[TB] FAIL midbeat_rdata: got %h expected 0", rdataV[0]); end
        re = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(0, 1'b1, 4'b0000, 19'h104, 32'h0, readyAt);
        checks++; if (readyAt != 5) begin errors++; $display("[TB] FAIL postreset_latency: got %0d expected 5", readyAt); end
        checks++; if (rdataV[0] !== 32'h08E3BE99) begin errors++; $display("[TB] FAIL postreset_data: got %h expected 08e3be99", rdataV[0]); end
    endtask

    task automatic test_strobe_exclusive;
        checks++; if (bothSeen !== 1'b0) begin errors++; $display("[TB] FAIL strobe_overlap: got %b expected 0", bothSeen); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bothSeen = 1'b0;
        reqReady = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 5);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        $display("[TB] starting");
        test_reset();
        test_read_byte();
        test_write_priority();
        test_write_sparse();
        test_read_half();
        test_write_skip_first();
        test_word_wrap();
        test_reset_midbeat();
        test_strobe_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
